// File: rtl/rv32i_fetch_buffer_pkg.sv
// Shared types for the RV32I fetch front-end: default widths and the
// buffered {instruction, next-PC} entry handed to decode.
package rv32i_fetch_pkg;

  localparam int                      PCW_DEFAULT      = 32;
  localparam logic [PCW_DEFAULT-1:0]  RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [31:0]            ir;
    logic [PCW_DEFAULT-1:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_buffer_if.sv
// Fetch-buffer bus: IMEM request/response, branch redirect and the decode
// handshake. master = fetch buffer, slave = its environment.
interface rv32i_fetch_buffer_if import rv32i_fetch_pkg::*; #(
  parameter int PCW = PCW_DEFAULT,
  parameter int CW  = 3
);
  logic           imem_req_valid;
  logic           imem_req_ready;
  logic [PCW-1:0] imem_req_addr;
  logic           imem_rsp_valid;
  logic [31:0]    imem_rsp_data;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_pc;
  logic           id_valid;
  logic           id_ready;
  logic [31:0]    id_ir;
  logic [PCW-1:0] id_npc;
  logic [CW-1:0]  fifo_count;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_ir, id_npc, fifo_count,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
           redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_ir, id_npc, fifo_count,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
           redirect_pc, id_ready
  );
endinterface

// File: rtl/rv32i_fetch_buffer_fifo.sv
// Synchronous FIFO of fetch entries with wrapping pointers, an occupancy
// count and a single-cycle flush. The head is read straight from storage.
module rv32i_fetch_fifo import rv32i_fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = 1;
  localparam logic [AW:0]     CNT_ONE  = 1;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // The credit rule upstream must make this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && full && !pop));

endmodule

// File: rtl/rv32i_fetch_buffer.sv
// Instruction fetch front-end: credit-limited word fetch, in-order response
// tracking with stale-response dropping after redirects, buffered to decode.
module rv32i_fetch_buffer import rv32i_fetch_pkg::*; #(
  parameter int             DEPTH    = 4,
  parameter int             PCW      = PCW_DEFAULT,
  parameter logic [PCW-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                 clk,
  input logic                 RN,
  rv32i_fetch_buffer_if.master bus
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [PCW-1:0] PC_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW:0]   CREDIT  = (CW+1)'(DEPTH);

  logic [PCW-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0]  outstanding, drop_cnt, fifo_count, rsp_dec;
  logic [CW:0]    inflight_sum;
  logic           started;
  logic           req_fire, rsp_fire, push, pop, fifo_empty;
  fetch_entry_t   push_entry, head;

  // Request valid waits one cycle after reset release so it is low throughout reset.
  assign inflight_sum       = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.imem_req_valid = started && !bus.redirect_valid && (inflight_sum < CREDIT);
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid;
  assign rsp_dec  = {{(CW-1){1'b0}}, rsp_fire};
  assign push     = rsp_fire && (drop_cnt == '0) && !bus.redirect_valid;
  assign pop      = !fifo_empty && bus.id_ready && !bus.redirect_valid;

  assign push_entry = '{ir: bus.imem_rsp_data, npc: rsp_pc + PC_ONE};

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      started <= 1'b1;
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc;
        rsp_pc   <= bus.redirect_pc;
        // Everything still in flight after this cycle is stale; drop_cnt is
        // already a subset of outstanding, so it is not added on top.
        drop_cnt <= outstanding - rsp_dec;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_ONE;
        if (push)     rsp_pc   <= rsp_pc + PC_ONE;
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_ONE;
      end
      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  rv32i_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (RN),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.id_valid   = !fifo_empty;
  assign bus.id_ir      = head.ir;
  assign bus.id_npc     = head.npc;
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_rv32i_fetch_buffer.sv
// Self-checking bench for rv32i_fetch_buffer: table-driven streaming and
// backpressure vectors plus hand-written redirect, random and reset sequences.
module tb_rv32i_fetch_buffer;
  import rv32i_fetch_pkg::*;

  logic clk = 1'b0;
  logic RN  = 1'b0;
  always #5 clk = ~clk;

  rv32i_fetch_buffer_if #(.PCW(32), .CW(3)) bus ();

  rv32i_fetch_buffer #(.DEPTH(4), .PCW(32), .RESET_PC(32'd0)) dut (
    .clk (clk),
    .RN  (RN),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;
  bit lat_rand = 1'b0;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] ir; logic [31:0] npc; } pop_t;
  req_t pend_q[$];
  pop_t got_q[$];

  typedef struct {
    bit          rst_before;
    bit          req_rdy;
    bit          id_rdy;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_npc;
    logic [2:0]  exp_cnt;
  } vec_t;
  vec_t vt[17];

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes, advance, then present any due IMEM response.
  task automatic tick();
    req_t r;
    pop_t p;
    int   l;
    int   last_due;
    #1;
    if (RN && bus.imem_req_valid && bus.imem_req_ready) begin
      l        = lat_rand ? int'($urandom_range(1, 3)) : lat;
      last_due = (pend_q.size() != 0) ? pend_q[$].due : cyc;
      r.addr   = bus.imem_req_addr;
      r.due    = (cyc + l > last_due) ? cyc + l : last_due + 1;
      pend_q.push_back(r);
    end
    if (RN && bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
      p.ir  = bus.id_ir;
      p.npc = bus.id_npc;
      got_q.push_back(p);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    RN = 1'b0;
    idle_inputs();
    pend_q.delete();
    got_q.delete();
    repeat (2) @(posedge clk);
    #1;
    RN  = 1'b1;
    cyc = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_valid"}, bus.imem_req_valid, 1'b0);
    chk({tag, " id_valid"},  bus.id_valid,       1'b0);
    chk({tag, " id_ir"},     bus.id_ir,          32'd0);
    chk({tag, " id_npc"},    bus.id_npc,         32'd0);
    chk({tag, " count"},     bus.fifo_count,     3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pops;
    logic [31:0] exp_npc;

    //            rst rr ir  rv addr iv npc cnt
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 3'd0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 1'b0, 32'd0, 3'd0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd2, 1'b1, 32'd1, 3'd1};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 32'd2, 3'd1};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 1'b1, 32'd3, 3'd1};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd5, 1'b1, 32'd4, 3'd1};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 3'd0};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0, 3'd0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd2, 1'b1, 32'd1, 3'd1};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 32'd1, 3'd2};
    vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'd1, 3'd3};
    vt[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, 3'd4};
    vt[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 1'b1, 32'd2, 3'd3};
    vt[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd5, 1'b1, 32'd3, 3'd2};
    vt[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd6, 1'b1, 32'd4, 3'd2};

    idle_inputs();
    RN = 1'b0;
    #2;
    chk_reset_outputs("por");

    lat = 1;
    for (int i = 0; i < 17; i++) begin
      if (vt[i].rst_before) do_reset();
      bus.imem_req_ready = vt[i].req_rdy;
      bus.id_ready       = vt[i].id_rdy;
      #1;
      chk($sformatf("v%0d req_valid", i), bus.imem_req_valid, vt[i].exp_rv);
      if (vt[i].exp_rv) chk($sformatf("v%0d req_addr", i), bus.imem_req_addr, vt[i].exp_addr);
      chk($sformatf("v%0d id_valid", i), bus.id_valid, vt[i].exp_iv);
      if (vt[i].exp_iv) begin
        chk($sformatf("v%0d id_npc", i), bus.id_npc, vt[i].exp_npc);
        chk($sformatf("v%0d id_ir", i),  bus.id_ir,  word(vt[i].exp_npc - 32'd1));
      end
      chk($sformatf("v%0d fifo_count", i), bus.fifo_count, vt[i].exp_cnt);
      tick();
    end

    // Redirect with three requests (6,7,8) still in flight.
    do_reset();
    lat = 5;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd6;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rd3 addr%0d", k), bus.imem_req_addr, 32'd6 + k);
      tick();
    end
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd25;
    #1;
    chk("rd3 no req in redirect", bus.imem_req_valid, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    #1;
    chk("rd3 req_valid after", bus.imem_req_valid, 1'b1);
    chk("rd3 req_addr after",  bus.imem_req_addr,  32'd25);
    tick();
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b0;
    n = 0;
    while (!bus.id_valid && n < 20) begin tick(); n++; end
    chk("rd3 id_valid", bus.id_valid, 1'b1);
    chk("rd3 id_ir",    bus.id_ir,    32'h1000_0019);
    chk("rd3 id_npc",   bus.id_npc,   32'd26);
    chk("rd3 count",    bus.fifo_count, 3'd1);

    // Redirect landing in the same cycle as the response for address 9.
    do_reset();
    lat = 2;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd9;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    #1;
    chk("rs addr9", bus.imem_req_addr, 32'd9);
    tick();
    bus.imem_req_ready = 1'b0;
    n = 0;
    while (!bus.imem_rsp_valid && n < 10) begin tick(); n++; end
    chk("rs rsp9 within bound", (n < 10), 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'd40;
    #1;
    chk("rs no req in redirect", bus.imem_req_valid, 1'b0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rs id_valid after", bus.id_valid,   1'b0);
    chk("rs count after",    bus.fifo_count, 3'd0);
    chk("rs req_addr after", bus.imem_req_addr, 32'd40);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b0;
    n = 0;
    while (!bus.id_valid && n < 10) begin tick(); n++; end
    chk("rs id_npc 41", bus.id_npc, 32'd41);
    chk("rs id_ir 40",  bus.id_ir,  32'h1000_0028);

    // Random IMEM readiness / latency 1..3, random decode stalls, one redirect.
    do_reset();
    lat_rand = 1'b1;
    exp_npc  = 32'd1;
    pops     = 0;
    for (int i = 0; i < 400; i++) begin
      bus.imem_req_ready = 1'($urandom_range(0, 1));
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = (i == 200);
      bus.redirect_pc    = 32'd100;
      tick();
      bus.redirect_valid = 1'b0;
      while (got_q.size() != 0) begin
        chk("rnd npc", got_q[0].npc, exp_npc);
        chk("rnd ir",  got_q[0].ir,  word(exp_npc - 32'd1));
        exp_npc = exp_npc + 32'd1;
        pops++;
        void'(got_q.pop_front());
      end
      if (i == 200) exp_npc = 32'd101;
    end
    bus.imem_req_ready = 1'b0;
    bus.id_ready       = 1'b1;
    repeat (20) begin
      tick();
      while (got_q.size() != 0) begin
        chk("rnd drain npc", got_q[0].npc, exp_npc);
        chk("rnd drain ir",  got_q[0].ir,  word(exp_npc - 32'd1));
        exp_npc = exp_npc + 32'd1;
        pops++;
        void'(got_q.pop_front());
      end
    end
    chk("rnd progress after redirect", (exp_npc >= 32'd140), 1'b1);
    chk("rnd drained count", bus.fifo_count, 3'd0);
    chk("rnd drained valid", bus.id_valid,   1'b0);
    lat_rand = 1'b0;

    // Reset asserted with two requests outstanding.
    do_reset();
    lat = 5;
    bus.id_ready       = 1'b1;
    bus.imem_req_ready = 1'b1;
    repeat (3) tick();
    bus.imem_req_ready = 1'b0;
    chk("mr two outstanding", pend_q.size(), 64'd2);
    RN = 1'b0;
    pend_q.delete();
    idle_inputs();
    #1;
    chk_reset_outputs("mid");
    repeat (2) @(posedge clk);
    #1;
    RN  = 1'b1;
    cyc = 0;
    bus.id_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b1;
    #1;
    chk("mr req_valid", bus.imem_req_valid, 1'b1);
    chk("mr req_addr",  bus.imem_req_addr,  32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
